// File: rtl/if_fetch_queue.sv
// Purpose: instruction fetch stage; owns the PC, addresses imem, queues {pc, instr} for decode.
// Latency: an instruction addressed in cycle t is presented on out_* in cycle t+1 at the earliest.
//          A redirect costs 2 bubble cycles.
// Backpressure: out_ready low fills the DEPTH-entry queue, then fetch stalls and imem_addr freezes.
//               While full, a same-cycle pop lets the next fetch proceed.
//
// Ports:
//   clk, rst                    clock; asynchronous active-high reset
//   imem_addr / imem_rdata      fetch address (the PC register); combinational instruction return
//   redirect_valid/redirect_pc  flush the queue and restart fetch at the target (bits [1:0] forced to 0)
//   out_valid/out_ready         handshake to decode
//   out_instr/out_pc            queue head (don't-care when out_valid is 0)
module if_fetch_queue #(
  parameter int           n        = 32,
  parameter logic [n-1:0] RESET_PC = '0,
  parameter int           DEPTH    = 4
) (
  input  logic         clk,
  input  logic         rst,
  output logic [n-1:0] imem_addr,
  input  logic [n-1:0] imem_rdata,
  input  logic         redirect_valid,
  input  logic [n-1:0] redirect_pc,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [n-1:0] out_instr,
  output logic [n-1:0] out_pc
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  typedef struct packed {
    logic [n-1:0] pc;
    logic [n-1:0] instr;
  } entry_t;

  entry_t         q [DEPTH];
  logic [n-1:0]   pc;
  logic [AW-1:0]  rd_ptr;
  logic [AW-1:0]  wr_ptr;
  logic [AW:0]    count;
  logic           push;
  logic           pop;

  // Word alignment is forced on the target, so the low bits never matter.
  logic unused_redirect_lsbs;
  assign unused_redirect_lsbs = &{1'b0, redirect_pc[1:0]};

  assign imem_addr = pc;

  // The head is always younger than a redirecting branch, so hide it during a redirect.
  assign out_valid = (count != '0) & ~redirect_valid;
  assign pop       = out_valid & out_ready;
  // A pop from a full queue frees the slot this cycle's fetch writes into.
  assign push      = ~redirect_valid & ((count < FULL) | pop);

  assign out_pc    = q[rd_ptr].pc;
  assign out_instr = q[rd_ptr].instr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc     <= RESET_PC;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (redirect_valid) begin
      pc     <= {redirect_pc[n-1:2], 2'b00};
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        pc     <= pc + n'(4);
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

  // Storage needs no reset: entries are only visible once count covers them.
  always_ff @(posedge clk) begin
    if (push) begin
      q[wr_ptr] <= '{pc: pc, instr: imem_rdata};
    end
  end

endmodule

// File: tb/tb_if_fetch_queue.sv
// Directed bench for if_fetch_queue: reset, streaming, stall/full, full with pop,
// async reset while full, redirect with queued entries, back-to-back redirect with PC wrap.
module tb_if_fetch_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  // Memory model: every word address returns a distinct, address-derived instruction.
  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return a ^ 32'h1357_0013;
  endfunction

  assign imem_rdata = instr_of(imem_addr);

  if_fetch_queue #(.n(32), .RESET_PC(32'h0), .DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Expected state for one cycle: valid flag, head pc (checked with its instr when valid), fetch addr.
  task automatic expect_cyc(input string tag, input logic v, input logic [31:0] p, input logic [31:0] a);
    chk({tag, ".valid"}, {31'b0, out_valid}, {31'b0, v});
    if (v) begin
      chk({tag, ".pc"}, out_pc, p);
      chk({tag, ".instr"}, out_instr, instr_of(p));
    end
    chk({tag, ".addr"}, imem_addr, a);
  endtask

  // Advance to just after the next rising edge; inputs are set then, checks follow #1 later.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  localparam logic [31:0] B = 32'd24;

  initial begin
    rst = 1'b1; out_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
    #1;
    expect_cyc("reset", 1'b0, 32'h0, 32'h0);

    // Release between edges; first cycle has nothing queued.
    cyc(); #1; rst = 1'b0; #1;
    expect_cyc("first", 1'b0, 32'h0, 32'h0);

    // Streaming with out_ready=1: one instruction per cycle from the second cycle.
    for (int i = 0; i < 6; i++) begin
      cyc(); #1;
      expect_cyc($sformatf("stream%0d", i), 1'b1, 32'(4*i), 32'(4*(i+1)));
    end

    // Stall 10 cycles: head holds at B, fetch fills 4 entries then freezes.
    for (int k = 0; k < 10; k++) begin
      cyc(); out_ready = 1'b0; #1;
      expect_cyc($sformatf("stall%0d", k), 1'b1, B, B + 32'(4*((k+1 < 4) ? k+1 : 4)));
    end

    // One cycle of pop while full: push proceeds in the same cycle.
    cyc(); out_ready = 1'b1; #1;
    expect_cyc("fullpop", 1'b1, B, B + 32'd16);
    for (int k = 0; k < 2; k++) begin
      cyc(); out_ready = 1'b0; #1;
      expect_cyc($sformatf("after_fullpop%0d", k), 1'b1, B + 32'd4, B + 32'd20);
    end

    // Drain in order, no gap or duplicate.
    for (int j = 0; j < 8; j++) begin
      cyc(); out_ready = 1'b1; #1;
      expect_cyc($sformatf("drain%0d", j), 1'b1, B + 32'(4*(j+1)), B + 32'(4*(j+5)));
    end

    // Queue full again; assert reset between edges.
    cyc(); out_ready = 1'b0; #1;
    expect_cyc("prefull", 1'b1, B + 32'd36, B + 32'd52);
    #2; rst = 1'b1; #1;
    expect_cyc("async_rst", 1'b0, 32'h0, 32'h0);
    cyc(); #2; rst = 1'b0; #1;
    expect_cyc("rst_rel", 1'b0, 32'h0, 32'h0);

    // Queue three entries with out_ready=0.
    for (int k = 1; k <= 3; k++) begin
      cyc(); #1;
      expect_cyc($sformatf("fill%0d", k), 1'b1, 32'h0, 32'(4*k));
    end

    // Redirect to 0x103 with 3 entries queued.
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0103; out_ready = 1'b1; #1;
    expect_cyc("redir_t", 1'b0, 32'h0, 32'hC);
    cyc(); redirect_valid = 1'b0; #1;
    expect_cyc("redir_t1", 1'b0, 32'h0, 32'h100);
    for (int k = 0; k < 3; k++) begin
      cyc(); #1;
      expect_cyc($sformatf("redir_tgt%0d", k), 1'b1, 32'h100 + 32'(4*k), 32'h104 + 32'(4*k));
    end

    // Back-to-back redirects: last target (0xFFFF_FFF8) wins, then PC wraps to 0.
    cyc(); redirect_valid = 1'b1; redirect_pc = 32'h0000_0200; #1;
    expect_cyc("b2b_a", 1'b0, 32'h0, 32'h110);
    cyc(); redirect_pc = 32'hFFFF_FFFA; #1;
    expect_cyc("b2b_b", 1'b0, 32'h0, 32'h200);
    cyc(); redirect_valid = 1'b0; #1;
    expect_cyc("b2b_t1", 1'b0, 32'h0, 32'hFFFF_FFF8);
    cyc(); #1;
    expect_cyc("wrap0", 1'b1, 32'hFFFF_FFF8, 32'hFFFF_FFFC);
    cyc(); #1;
    expect_cyc("wrap1", 1'b1, 32'hFFFF_FFFC, 32'h0);
    cyc(); #1;
    expect_cyc("wrap2", 1'b1, 32'h0, 32'h4);
    cyc(); #1;
    expect_cyc("wrap3", 1'b1, 32'h4, 32'h8);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
